mult_booth: RTL
===============

// Module: mult_booth
// PURPOSE
//   Sequential signed multiplier using radix-2 Booth encoding; one Booth step per clock.
//   Sits between the AuxMultDivA/AuxMultDivB operand registers and the HI/LOW registers.
//   Driven by the control unit through start/busy/done. HI/LOW latch hi/lo when done=1.
// PARAMETERS
//   WIDTH  32  operand width; product is 2*WIDTH, split into hi/lo
// PORTS
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous, active-low reset (0 = reset)
//   start  in   1      request; sampled only in IDLE or DONE
//   a      in   WIDTH  multiplicand (signed), sampled with start
//   b      in   WIDTH  multiplier (signed), sampled with start
//   busy   out  1      1 while in RUN
//   done   out  1      1-cycle pulse; hi/lo valid from this cycle on
//   hi     out  WIDTH  product[2*WIDTH-1:WIDTH]
//   lo     out  WIDTH  product[WIDTH-1:0]
// BEHAVIOUR
//   States: IDLE, RUN, DONE.
//   Reset (reset=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, internal regs=0.
//   IDLE/DONE & start=1 at edge E0:
//     - M<=a, Q<=b, Q_1<=0, ACC<=0, count<=WIDTH, state<=RUN.
//   IDLE/DONE & start=0: state<=IDLE. DONE always lasts exactly 1 cycle.
//   RUN, each edge (one Booth step), selected by {Q[0],Q_1}:
//     - 01: ACC+=M; 10: ACC-=M; 00/11: no add.
//     - Then arithmetic right shift of {ACC,Q,Q_1} by 1; count-=1.
//   Width rule: ACC is WIDTH+1 bits; M is sign-extended to WIDTH+1 bits.
//     This keeps M=-2^(WIDTH-1) exact.
//   Last step (count==1 at edge E(WIDTH)):
//     - hi<=ACC[WIDTH-1:0] after shift; lo<=Q after shift; state<=DONE.
//   Latency: done=1 in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after start was seen.
//   busy=1 from after E0 through E(WIDTH). busy and done are never both 1.
//   start during RUN: ignored. Operands are not re-sampled and the operation is not restarted.
//   start in DONE: accepted. Back-to-back operations lose no cycle.
//   hi/lo hold their last result until the next completion.
//     They are never updated mid-RUN, so HI/LOW may read them at any time.
//   Reset mid-RUN: aborts immediately. All outputs go to their reset values; no done pulse.
//   Result is the exact two's-complement 2*WIDTH-bit product. There is no overflow flag.
// CONFIGURATION
//   MULT_ZERO_SKIP_EN defined:
//     - If start is seen in IDLE/DONE with a==0 or b==0, go straight to DONE.
//     - hi<=0, lo<=0, done=1 in the cycle after E0, busy stays 0.
//   MULT_ZERO_SKIP_EN undefined:
//     - Zero operands take the full WIDTH+1 cycle latency like any other operands.
// TESTING
//   1. reset=0 then 1; a=7, b=6, start for 1 cycle:
//        busy for 32 cycles, then done pulse; hi=0x00000000, lo=0x0000002A.
//   2. a=-3 (0xFFFFFFFD), b=5:
//        hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//   3. a=b=0x80000000:
//        hi=0x40000000, lo=0x00000000.
//      a=0x80000000, b=0x7FFFFFFF:
//        hi=0xC0000000, lo=0x80000000.
//   4. a=2, b=3, then start pulsed again in cycle 10 with a=9, b=9:
//        still done at cycle 33 with lo=6. Start held into DONE: second op begins, lo=81.
//   5. reset=0 in cycle 15 of a run:
//        busy=0, done=0, hi=lo=0 immediately; no done pulse; next start works normally.
//   6. a=0, b=0x1234:
//        with MULT_ZERO_SKIP_EN, done in cycle 1, busy never 1.
//        without it, done at cycle 33.
//        Both give hi=lo=0.

Source files
------------

// File: rtl/mult_booth_if.sv
// Operand/result bundle between the control unit and the Booth multiplier.
interface mult_booth_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, a, b, input  busy, done, hi, lo);
  modport slave  (input  start, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_booth.sv
// Sequential signed radix-2 Booth multiplier, one step per clock, 2*WIDTH-bit product on hi/lo.
// Optional MULT_ZERO_SKIP_EN: a zero operand completes in a single cycle.
module mult_booth #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  mult_booth_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [AW-1:0]    acc, acc_d, m, m_d, sum;
  logic [WIDTH-1:0] q, q_d, hi, hi_d, lo, lo_d;
  logic             q_1, q_1_d, busy, busy_d, done, done_d;
  logic [CW-1:0]    count, count_d;
  logic             zero_op;

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Booth add/subtract selected by the current multiplier bit pair
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      m     <= m_d;
      q     <= q_d;
      q_1   <= q_1_d;
      count <= count_d;
      hi    <= hi_d;
      lo    <= lo_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    m_d     = m;
    q_d     = q;
    q_1_d   = q_1;
    count_d = count;
    hi_d    = hi;
    lo_d    = lo;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (zero_op) begin
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Sign-extend M into WIDTH+1 bits so -2^(WIDTH-1) negates exactly
            m_d     = {bus.a[WIDTH-1], bus.a};
            q_d     = bus.b;
            q_1_d   = 1'b0;
            acc_d   = '0;
            count_d = CW'(WIDTH);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Arithmetic right shift of {ACC,Q,Q_1}
        acc_d   = {sum[AW-1], sum[AW-1:1]};
        q_d     = {sum[0], q[WIDTH-1:1]};
        q_1_d   = q[0];
        count_d = count - CW'(1);
        if (count == CW'(1)) begin
          hi_d    = acc_d[WIDTH-1:0];
          lo_d    = q_d;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
endmodule
